// File: rtl/elastic_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe_pkg
// Description : Shared helper for the elastic pipeline. Provides the width
//               calculation for the occupancy counter so that the port width
//               and the internal counter are always derived the same way.
// Revision    : 1.0 - initial release
// ============================================================================
package elastic_pipe_pkg;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : elastic_pipe_pkg
`default_nettype wire

// File: rtl/elastic_stage.sv
`default_nettype none
// ============================================================================
// Module      : elastic_stage
// Description : One stage of the elastic pipeline: a WIDTH-bit data register
//               paired with a valid flag.
//                 clk    - system clock
//                 reset  - synchronous active-high reset (valid=0, data=0)
//                 flush  - clears the valid flag, data is left untouched
//                 load   - capture d and mark the stage valid
//                 drain  - the held word moves downstream this cycle
//                 d      - incoming word
//                 valid  - stage holds a live word
//                 q      - stored word
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Valid flag: flush wins over a simultaneous load, so a word moving
    // between stages in the flush cycle is discarded with everything else.
    // A load while draining keeps the stage valid (word replaced in place).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end

    // Data register is a plain enabled reset flop: it changes only on a
    // load event and otherwise holds, even when the stage is invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= d;
        end
    end

    assign valid = r_valid;
    assign q     = r_data;

endmodule : elastic_stage
`default_nettype wire

// File: rtl/elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe
// Description : Stallable, flushable register pipeline of DEPTH stages with
//               valid/ready handshakes on both sides. Bubbles collapse while
//               the output is stalled; ready passes through a full pipe.
//                 clk       - system clock
//                 reset     - synchronous active-high reset
//                 flush     - drop every word held in the pipe
//                 in_valid  - upstream presents in_data
//                 in_data   - upstream word
//                 in_ready  - pipe accepts in_data this cycle
//                 out_valid - out_data is valid (registered)
//                 out_data  - word from the last stage (registered)
//                 out_ready - downstream accepts out_data this cycle
//                 occupancy - number of valid stages (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    if (DEPTH < 1) begin : g_depth_check
        $error("elastic_pipe: DEPTH must be >= 1");
    end

    logic [DEPTH-1:0] w_stage_valid;
    logic [WIDTH-1:0] w_stage_data [DEPTH];
    logic [WIDTH-1:0] w_stage_d    [DEPTH];
    // w_take[i]: stage i can capture a word this cycle. The extra top bit
    // stands for the downstream consumer so the advance rule is uniform.
    logic [DEPTH:0]   w_take;
    logic [DEPTH-1:0] w_adv;
    logic [DEPTH-1:0] w_load;
    logic             w_accept;
    logic             w_emit;
    logic [OCC_W-1:0] r_occupancy;

    assign w_take[DEPTH] = out_ready;

    // take[i] = !valid[i] | (valid[i] & take[i+1]) reduces to: downstream is
    // ready, or some stage from i to the output is empty. Writing it in the
    // flattened form keeps the chain free of self-referencing vector bits.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        assign w_take[gi] = out_ready | ~(&w_stage_valid[DEPTH-1:gi]);
        assign w_adv[gi]  = w_stage_valid[gi] & w_take[gi+1];

        if (gi == 0) begin : g_head
            assign w_load[gi]    = w_accept;
            assign w_stage_d[gi] = in_data;
        end else begin : g_body
            assign w_load[gi]    = w_take[gi] & w_stage_valid[gi-1];
            assign w_stage_d[gi] = w_stage_data[gi-1];
        end

        elastic_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .load  (w_load[gi]),
            .drain (w_adv[gi]),
            .d     (w_stage_d[gi]),
            .valid (w_stage_valid[gi]),
            .q     (w_stage_data[gi])
        );
    end

    assign in_ready = w_take[0] & ~flush;
    assign w_accept = in_valid & in_ready;
    // An emit in the flush cycle still counts as delivered downstream.
    assign w_emit   = w_stage_valid[DEPTH-1] & out_ready;

    // Occupancy tracks the population of valid flags incrementally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occupancy <= '0;
        end else if (flush) begin
            r_occupancy <= '0;
        end else if (w_accept && !w_emit) begin
            r_occupancy <= r_occupancy + OCC_W'(1);
        end else if (!w_accept && w_emit) begin
            r_occupancy <= r_occupancy - OCC_W'(1);
        end
    end

    assign out_valid = w_stage_valid[DEPTH-1];
    assign out_data  = w_stage_data[DEPTH-1];
    assign occupancy = r_occupancy;

endmodule : elastic_pipe
`default_nettype wire
